// File: rtl/axby_ctrl_if.sv
`timescale 1ns/1ps
// Control bundle between the A*X+B*Y sequencer and its user/datapath.
// master drives start/a/b; slave (axby_ctrl) drives the controls.
interface axby_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         plx;
  logic         ply;
  logic         clrrez;
  logic         shiftx;
  logic         shifty;
  logic         sel;
  logic         plrez;
  logic         incxy;
  logic         busy;
  logic         done;
  logic [4:0]   Status;

  modport master (
    output start, a, b,
    input  plx, ply, clrrez,
    input  shiftx, shifty, sel,
    input  plrez, incxy,
    input  busy, done, Status
  );

  modport slave (
    input  start, a, b,
    output plx, ply, clrrez,
    output shiftx, shifty, sel,
    output plrez, incxy,
    output busy, done, Status
  );
endinterface

// File: rtl/axby_ctrl.sv
`timescale 1ns/1ps
// Sequencer for the shift-add A*X+B*Y datapath (IDLE/LOAD/XPH/YPH/DONE).
// Define AXBY_SKIP_ZERO_EN to end a phase early once remaining bits are 0.
module axby_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic        clk,
  input  logic        reset,
  axby_ctrl_if.slave  bus
);

  localparam int I_IDLE = 0;
  localparam int I_LOAD = 1;
  localparam int I_XPH  = 2;
  localparam int I_YPH  = 3;
  localparam int I_DONE = 4;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_LOAD = 5'b00010;
  localparam logic [4:0] S_XPH  = 5'b00100;
  localparam logic [4:0] S_YPH  = 5'b01000;
  localparam logic [4:0] S_DONE = 5'b10000;

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  logic [4:0]    r_state;
  logic [4:0]    w_next;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_a_sh;
  logic [N-1:0]  r_b_sh;
  logic [N-1:0]  w_rem;
  logic          w_last;

  assign w_rem = r_state[I_YPH] ? (r_b_sh >> 1)
                                : (r_a_sh >> 1);

`ifdef AXBY_SKIP_ZERO_EN
  assign w_last = (r_cnt == C_LAST) || (w_rem == '0);
`else
  logic w_unused;
  assign w_unused = ^w_rem;
  assign w_last   = (r_cnt == C_LAST);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      r_state[I_IDLE]: w_next = bus.start ? S_LOAD : S_IDLE;
      r_state[I_LOAD]: w_next = S_XPH;
      r_state[I_XPH]:  w_next = w_last ? S_YPH : S_XPH;
      r_state[I_YPH]:  w_next = w_last ? S_DONE : S_YPH;
      r_state[I_DONE]: w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  // Operand shifters and step counter; counter re-arms at each phase end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
    end else if (r_state[I_LOAD]) begin
      r_cnt  <= '0;
      r_a_sh <= bus.a;
      r_b_sh <= bus.b;
    end else if (r_state[I_XPH]) begin
      r_a_sh <= r_a_sh >> 1;
      r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
    end else if (r_state[I_YPH]) begin
      r_b_sh <= r_b_sh >> 1;
      r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  always_comb begin
    bus.plx    = 1'b0;
    bus.ply    = 1'b0;
    bus.clrrez = 1'b0;
    bus.shiftx = 1'b0;
    bus.shifty = 1'b0;
    bus.sel    = 1'b0;
    bus.plrez  = 1'b0;
    bus.incxy  = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (1'b1)
      r_state[I_LOAD]: begin
        bus.plx    = 1'b1;
        bus.ply    = 1'b1;
        bus.clrrez = 1'b1;
        bus.busy   = 1'b1;
      end
      r_state[I_XPH]: begin
        bus.plrez  = r_a_sh[0];
        bus.shiftx = 1'b1;
        bus.incxy  = 1'b1;
        bus.busy   = 1'b1;
      end
      r_state[I_YPH]: begin
        bus.sel    = 1'b1;
        bus.plrez  = r_b_sh[0];
        bus.shifty = 1'b1;
        bus.incxy  = 1'b1;
        bus.busy   = 1'b1;
      end
      r_state[I_DONE]: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.Status = r_state;

endmodule

// File: tb/tb_axby_ctrl.sv
`timescale 1ns/1ps
// Directed bench for axby_ctrl with a small shift-add datapath model.
module tb_axby_ctrl;

  logic clk;
  logic rst_n;
  int   n_asrt;
  int   n_fail;

  logic [7:0]  xin;
  logic [7:0]  yin;
  logic [15:0] xr;
  logic [15:0] yr;
  logic [15:0] acc;

  axby_ctrl_if bus ();

  axby_ctrl dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.plx) xr <= {8'h00, xin};
    else if (bus.shiftx) xr <= xr << 1;
    if (bus.ply) yr <= {8'h00, yin};
    else if (bus.shifty) yr <= yr << 1;
    if (bus.clrrez) acc <= '0;
    else if (bus.plrez) acc <= acc + (bus.sel ? yr : xr);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctl();
    return {bus.plx, bus.ply, bus.clrrez, bus.shiftx,
            bus.shifty, bus.sel, bus.plrez, bus.incxy,
            bus.busy, bus.done};
  endfunction

  task automatic run(input  logic [7:0] av,
                     input  logic [7:0] bv,
                     input  int         chg,
                     input  logic [7:0] cv,
                     output logic [7:0] xp,
                     output logic [7:0] yp,
                     output int         ninc,
                     output int         dcyc,
                     output int         ndone,
                     output logic [15:0] res);
    int xi;
    int yi;
    xp = '0; yp = '0; ninc = 0;
    dcyc = -1; ndone = 0; res = '0;
    xi = 0; yi = 0;
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == chg) bus.a = cv;
      check("onehot", 32'($onehot(bus.Status)), 32'd1);
      check("xy_excl", 32'(bus.shiftx & bus.shifty), 32'd0);
      if (cyc == 1) check("busy_load", 32'(bus.busy), 32'd1);
      if (bus.incxy) ninc++;
      if (bus.shiftx && xi < 8) begin
        xp[xi] = bus.plrez; xi++;
      end
      if (bus.shifty && yi < 8) begin
        yp[yi] = bus.plrez; yi++;
      end
      if (bus.done) begin
        ndone++;
        check("busy_done", 32'(bus.busy), 32'd0);
        if (dcyc < 0) begin
          dcyc = cyc; res = acc;
        end
      end
    end
  endtask

  logic [7:0]  xp;
  logic [7:0]  yp;
  int          ninc;
  int          dcyc;
  int          ndone;
  logic [15:0] res;

  initial begin
    n_asrt = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    xin = 8'd5; yin = 8'd7;
    repeat (2) @(negedge clk);
    check("rst_status", 32'(bus.Status), 32'h01);
    check("rst_ctl", 32'(ctl()), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_status", 32'(bus.Status), 32'h01);

`ifdef AXBY_SKIP_ZERO_EN
    run(8'h01, 8'h04, 0, 8'h00, xp, yp, ninc, dcyc, ndone, res);
    check("skip_done_cyc", 32'(dcyc), 32'd6);
    check("skip_incxy", 32'(ninc), 32'd4);
    check("skip_ypat", 32'(yp), 32'h04);
    check("skip_ndone", 32'(ndone), 32'd1);
    check("skip_res", 32'(res), 32'd33);
`else
    run(8'd3, 8'd2, 0, 8'h00, xp, yp, ninc, dcyc, ndone, res);
    check("basic_xpat", 32'(xp), 32'h03);
    check("basic_ypat", 32'(yp), 32'h02);
    check("basic_done_cyc", 32'(dcyc), 32'd18);
    check("basic_ndone", 32'(ndone), 32'd1);
    check("basic_incxy", 32'(ninc), 32'd16);
    check("basic_res", 32'(res), 32'd29);

    // abort during the fourth X step
    @(negedge clk);
    bus.a = 8'd3; bus.b = 8'd2; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_status", 32'(bus.Status), 32'h04);
    rst_n = 1'b0;
    #1;
    check("mid_rst_status", 32'(bus.Status), 32'h01);
    check("mid_rst_ctl", 32'(ctl()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'd3, 8'd2, 0, 8'h00, xp, yp, ninc, dcyc, ndone, res);
    check("post_rst_done_cyc", 32'(dcyc), 32'd18);
    check("post_rst_res", 32'(res), 32'd29);

    // start held high across a whole run
    ndone = 0; dcyc = -1;
    @(negedge clk);
    bus.a = 8'd3; bus.b = 8'd2; bus.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (dcyc < 0) dcyc = cyc;
      end
      if (cyc == 19) check("hold_idle19", 32'(bus.Status), 32'h01);
      if (cyc == 20) begin
        check("hold_load20", 32'(bus.Status), 32'h02);
        bus.start = 1'b0;
      end
    end
    check("hold_ndone", 32'(ndone), 32'd1);
    check("hold_done_cyc", 32'(dcyc), 32'd18);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run(8'h00, 8'hFF, 0, 8'h00, xp, yp, ninc, dcyc, ndone, res);
    check("zero_xpat", 32'(xp), 32'h00);
    check("zero_ypat", 32'(yp), 32'hFF);
    check("zero_incxy", 32'(ninc), 32'd16);
    check("zero_done_cyc", 32'(dcyc), 32'd18);
    check("zero_res", 32'(res), 32'd1785);

    run(8'h81, 8'h00, 3, 8'h00, xp, yp, ninc, dcyc, ndone, res);
    check("stable_xpat", 32'(xp), 32'h81);
    check("stable_ypat", 32'(yp), 32'h00);
    check("stable_res", 32'(res), 32'd645);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
